// File: rtl/div_result_fifo.sv
// Show-ahead result FIFO between the divider and its consumer.
// Keeps a sticky overflow flag and a saturating accepted-result count.
module div_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     div_done,
  input  logic [W-1:0]             div_q,
  input  logic [W-1:0]             div_s,
  input  logic                     div_dz,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic                     out_valid,
  output logic [W-1:0]             out_q,
  output logic [W-1:0]             out_s,
  output logic                     out_dz,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic         dz;
    logic [W-1:0] s;
    logic [W-1:0] q;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     total_q, total_d;

  logic pop;
  logic push;
  logic drop;
  entry_t head;

  // Handshake decode: a full FIFO still takes a push when it pops.
  always_comb begin
    pop  = (count_q != '0) && out_ready;
    push = div_done && ((count_q < FULL) || pop);
    drop = div_done && !push;
  end

  // Next-state for storage, pointers, occupancy and status.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    total_d  = total_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{dz: div_dz, s: div_s, q: div_q};
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (total_q != 16'hFFFF) begin
        total_d = total_q + 16'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear wins.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (err_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; storage is cleared so empty data is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      total_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      total_q  <= total_d;
    end
  end

  // Head entry is presented straight from the read pointer.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = (count_q != '0);
    out_q     = head.q;
    out_s     = head.s;
    out_dz    = head.dz;
    count     = count_q;
    overflow  = ovf_q;
    total     = total_q;
  end

endmodule

// File: tb/tb_div_result_fifo.sv
// Bench for div_result_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_div_result_fifo;

  localparam int DEPTH = 4;
  localparam int W     = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         div_done;
  logic [W-1:0] div_q;
  logic [W-1:0] div_s;
  logic         div_dz;
  logic         out_ready;
  logic         err_clr;
  logic         out_valid;
  logic [W-1:0] out_q;
  logic [W-1:0] out_s;
  logic         out_dz;
  logic [$clog2(DEPTH):0] count;
  logic         overflow;
  logic [15:0]  total;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] s;
    logic         dz;
  } ent_t;

  ent_t m_fifo[$];
  bit   m_ovf;
  int   m_total;

  div_result_fifo #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .div_done(div_done), .div_q(div_q), .div_s(div_s),
    .div_dz(div_dz), .out_ready(out_ready), .err_clr(err_clr),
    .out_valid(out_valid), .out_q(out_q), .out_s(out_s),
    .out_dz(out_dz), .count(count), .overflow(overflow),
    .total(total)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_ovf   = 0;
    m_total = 0;
  endtask

  task automatic check_all();
    chk("valid", {31'd0, out_valid}, {31'd0, m_fifo.size() != 0});
    chk("count", 32'(count), 32'(m_fifo.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("total", 32'(total), 32'(m_total));
    chk("data_known", {31'd0, $isunknown({out_q, out_s, out_dz})}, 32'd0);
    if (m_fifo.size() != 0) begin
      chk("head_q", 32'(out_q), 32'(m_fifo[0].q));
      chk("head_s", 32'(out_s), 32'(m_fifo[0].s));
      chk("head_dz", {31'd0, out_dz}, {31'd0, m_fifo[0].dz});
    end
  endtask

  task automatic step(bit d, logic [W-1:0] q, logic [W-1:0] s,
                      bit dz, bit rdy, bit clr, bit do_chk = 1);
    bit   pop;
    bit   push;
    ent_t e;
    div_done  = d;
    div_q     = q;
    div_s     = s;
    div_dz    = dz;
    out_ready = rdy;
    err_clr   = clr;
    pop  = (m_fifo.size() != 0) && rdy;
    push = d && ((m_fifo.size() < DEPTH) || pop);
    @(posedge clk);
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      e.q = q;
      e.s = s;
      e.dz = dz;
      m_fifo.push_back(e);
      if (m_total < 65535) m_total++;
    end
    if (d && !push) m_ovf = 1;
    else if (clr) m_ovf = 0;
    #1;
    div_done  = 0;
    out_ready = 0;
    err_clr   = 0;
    if (do_chk) check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst_n = 0;
    div_done = 0; div_q = 0; div_s = 0; div_dz = 0;
    out_ready = 0; err_clr = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_q", 32'(out_q), 32'd0);
    chk("rst_s", 32'(out_s), 32'd0);
    chk("rst_dz", {31'd0, out_dz}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Scenario 1: pass-through, visible one cycle after push.
    step(1, 9'd12, 9'd3, 0, 1, 0);
    chk("s1_q", 32'(out_q), 32'd12);
    chk("s1_s", 32'(out_s), 32'd3);
    step(0, 0, 0, 0, 1, 0);
    chk("s1_empty", {31'd0, out_valid}, 32'd0);
    chk("s1_total", 32'(total), 32'd1);
    step(0, 0, 0, 0, 1, 0);

    // Scenario 2: fill then overflow, drain in order.
    for (int i = 1; i <= 5; i++) step(1, 9'(i), 9'(i + 20), 0, 0, 0);
    chk("s2_count", 32'(count), 32'd4);
    chk("s2_ovf", {31'd0, overflow}, 32'd1);
    chk("s2_total", 32'(total), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      chk("s2_drain", 32'(out_q), 32'(i));
      step(0, 0, 0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("s2_clr", {31'd0, overflow}, 32'd0);

    // Scenario 3: full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) step(1, 9'(i), 9'd0, 0, 0, 0);
    step(1, 9'd9, 9'd1, 0, 1, 0);
    chk("s3_count", 32'(count), 32'd4);
    chk("s3_ovf", {31'd0, overflow}, 32'd0);
    drain();

    // Scenario 4: push/pop pairs at count 1 across pointer wrap.
    step(1, 9'd0, 9'd100, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(1, 9'(i), 9'(100 + i), 0, 1, 0);
    drain();
    step(0, 0, 0, 0, 1, 0);

    // Scenario 5: divide-by-zero entry and clear-vs-set priority.
    step(1, 9'h1FF, 9'd0, 1, 0, 0);
    chk("s5_dz", {31'd0, out_dz}, 32'd1);
    for (int i = 0; i < 3; i++) step(1, 9'(i), 9'd7, 0, 0, 0);
    step(1, 9'd50, 9'd50, 0, 0, 1);
    chk("s5_set_wins", {31'd0, overflow}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("s5_clr", {31'd0, overflow}, 32'd0);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 9'($urandom), 9'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0);
    end
    drain();

    // Scenario 6: asynchronous reset with entries held.
    for (int i = 0; i < 3; i++) step(1, 9'(i + 1), 9'd2, 0, 0, 0);
    chk("s6_count3", 32'(count), 32'd3);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("s6_valid", {31'd0, out_valid}, 32'd0);
    chk("s6_count", 32'(count), 32'd0);
    chk("s6_total", 32'(total), 32'd0);
    chk("s6_q", 32'(out_q), 32'd0);
    @(negedge clk);
    rst_n = 1;
    step(1, 9'd77, 9'd5, 0, 0, 0);
    chk("s6_first", 32'(out_q), 32'd77);
    drain();

    // Saturation of the accepted-result counter.
    for (int i = 0; i < 65540; i++) step(1, 9'(i), 9'd0, 0, 1, 0, 0);
    check_all();
    chk("sat_total", 32'(total), 32'hFFFF);
    step(1, 9'd3, 9'd0, 0, 1, 0);
    chk("sat_hold", 32'(total), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
